// File: rtl/rs_issue_sched_pkg.sv
// Shared definitions for the reservation-station issue scheduler:
// function codes, mul/div FSM states and the round-robin pointer helper.
package rs_issue_sched_pkg;

  localparam int ROB_W  = 3;
  localparam int FUNC_W = 4;
  localparam int IDX_W  = 2;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;
  localparam logic [FUNC_W-1:0] FUNC_MUL = 4'b0010;
  localparam logic [FUNC_W-1:0] FUNC_DIV = 4'b0011;
  localparam logic [FUNC_W-1:0] FUNC_LD  = 4'b0100;
  localparam logic [FUNC_W-1:0] FUNC_ST  = 4'b0101;
  localparam logic [FUNC_W-1:0] FUNC_BEQ = 4'b0110;
  localparam logic [FUNC_W-1:0] FUNC_BNE = 4'b0111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // Pointer value following a grant at idx, wrapping at num_ent.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int num_ent);
    if (int'(idx) >= num_ent - 1) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/rs_issue_sched_rr_picker.sv
// Round-robin picker: first set request at or after ptr (wrapping) wins,
// reported both one-hot and encoded.
module rs_issue_sched_rr_picker
  import rs_issue_sched_pkg::*;
#(
  parameter int NUM_ENT = 3
) (
  input  logic [NUM_ENT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_ENT-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand_s;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % NUM_ENT);
  endfunction

  // Scan the request vector starting at the pointer.
  always_comb begin
    grant  = {NUM_ENT{1'b0}};
    idx    = {IDX_W{1'b0}};
    valid  = 1'b0;
    cand_s = {IDX_W{1'b0}};
    for (int off = 0; off < NUM_ENT; off++) begin
      cand_s = wrap_add(ptr, off);
      if (!valid && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        idx           = cand_s;
        valid         = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// Issue scheduler: round-robin grants from the add and mul stations, launch
// into the add pipe / multi-cycle mul-div unit, and CDB arbitration.
module rs_issue_sched
  import rs_issue_sched_pkg::*;
#(
  parameter int NUM_ENT = 3,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_ENT-1:0]        add_req,
  input  logic [NUM_ENT*FUNC_W-1:0] add_func,
  input  logic [NUM_ENT*ROB_W-1:0]  add_rob,
  input  logic [NUM_ENT-1:0]        mul_req,
  input  logic [NUM_ENT*FUNC_W-1:0] mul_func,
  input  logic [NUM_ENT*ROB_W-1:0]  mul_rob,
  output logic [NUM_ENT-1:0]        add_grant,
  output logic [NUM_ENT-1:0]        mul_grant,
  output logic                      add_issue_valid,
  output logic [IDX_W-1:0]          add_issue_idx,
  output logic [FUNC_W-1:0]         add_issue_func,
  output logic [ROB_W-1:0]          add_issue_rob,
  output logic                      mul_issue_valid,
  output logic [IDX_W-1:0]          mul_issue_idx,
  output logic [FUNC_W-1:0]         mul_issue_func,
  output logic [ROB_W-1:0]          mul_issue_rob,
  output logic                      mul_busy,
  output logic                      cdb_valid,
  output logic                      cdb_src,
  output logic [ROB_W-1:0]          cdb_rob
);

  localparam int CNT_W = (DIV_LAT > MUL_LAT) ? $clog2(DIV_LAT) : $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_e         state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   add_ptr_r, mul_ptr_r;
  logic [NUM_ENT-1:0] add_pick_grant_s, mul_pick_grant_s;
  logic [IDX_W-1:0]   add_pick_idx_s, mul_pick_idx_s;
  logic               add_pick_valid_s, mul_pick_valid_s;
  logic               add_fire_s, mul_fire_s;
  logic [FUNC_W-1:0]  add_func_arr_s [NUM_ENT];
  logic [FUNC_W-1:0]  mul_func_arr_s [NUM_ENT];
  logic [ROB_W-1:0]   add_rob_arr_s  [NUM_ENT];
  logic [ROB_W-1:0]   mul_rob_arr_s  [NUM_ENT];
  logic [FUNC_W-1:0]  add_sel_func_s, mul_sel_func_s;
  logic [ROB_W-1:0]   add_sel_rob_s, mul_sel_rob_s;
  logic               add_res_valid_r;
  logic [ROB_W-1:0]   add_res_rob_r;
  logic               mul_busy_s, mul_done_s;

  for (genvar g = 0; g < NUM_ENT; g++) begin : g_unpack
    assign add_func_arr_s[g] = add_func[g*FUNC_W +: FUNC_W];
    assign mul_func_arr_s[g] = mul_func[g*FUNC_W +: FUNC_W];
    assign add_rob_arr_s[g]  = add_rob[g*ROB_W +: ROB_W];
    assign mul_rob_arr_s[g]  = mul_rob[g*ROB_W +: ROB_W];
  end

  rs_issue_sched_rr_picker #(.NUM_ENT(NUM_ENT)) u_add_pick (
    .req   (add_req),
    .ptr   (add_ptr_r),
    .grant (add_pick_grant_s),
    .idx   (add_pick_idx_s),
    .valid (add_pick_valid_s)
  );

  rs_issue_sched_rr_picker #(.NUM_ENT(NUM_ENT)) u_mul_pick (
    .req   (mul_req),
    .ptr   (mul_ptr_r),
    .grant (mul_pick_grant_s),
    .idx   (mul_pick_idx_s),
    .valid (mul_pick_valid_s)
  );

  // Gate picks: adds pause while a mul result waits, mul needs an idle unit.
  always_comb begin
    if (!flush && (state_r != MUL_DONE)) begin
      add_grant  = add_pick_grant_s;
      add_fire_s = add_pick_valid_s;
    end else begin
      add_grant  = {NUM_ENT{1'b0}};
      add_fire_s = 1'b0;
    end
    if (!flush && (state_r == MUL_IDLE)) begin
      mul_grant  = mul_pick_grant_s;
      mul_fire_s = mul_pick_valid_s;
    end else begin
      mul_grant  = {NUM_ENT{1'b0}};
      mul_fire_s = 1'b0;
    end
  end

  // Fetch func and ROB index of the picked entries.
  always_comb begin
    add_sel_func_s = {FUNC_W{1'b0}};
    add_sel_rob_s  = {ROB_W{1'b0}};
    mul_sel_func_s = {FUNC_W{1'b0}};
    mul_sel_rob_s  = {ROB_W{1'b0}};
    for (int i = 0; i < NUM_ENT; i++) begin
      if (add_pick_grant_s[i]) begin
        add_sel_func_s = add_func_arr_s[i];
        add_sel_rob_s  = add_rob_arr_s[i];
      end else begin
        add_sel_rob_s  = add_sel_rob_s;
      end
      if (mul_pick_grant_s[i]) begin
        mul_sel_func_s = mul_func_arr_s[i];
        mul_sel_rob_s  = mul_rob_arr_s[i];
      end else begin
        mul_sel_rob_s  = mul_sel_rob_s;
      end
    end
  end

  // Round-robin pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_ptr_r <= {IDX_W{1'b0}};
      mul_ptr_r <= {IDX_W{1'b0}};
    end else if (flush) begin
      add_ptr_r <= {IDX_W{1'b0}};
      mul_ptr_r <= {IDX_W{1'b0}};
    end else begin
      if (add_fire_s) add_ptr_r <= rr_next(add_pick_idx_s, NUM_ENT);
      if (mul_fire_s) mul_ptr_r <= rr_next(mul_pick_idx_s, NUM_ENT);
    end
  end

  // Add launch register and one-stage add result slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_issue_valid <= 1'b0;
      add_issue_idx   <= {IDX_W{1'b0}};
      add_issue_func  <= {FUNC_W{1'b0}};
      add_issue_rob   <= {ROB_W{1'b0}};
      add_res_valid_r <= 1'b0;
      add_res_rob_r   <= {ROB_W{1'b0}};
    end else if (flush) begin
      add_issue_valid <= 1'b0;
      add_res_valid_r <= 1'b0;
    end else begin
      add_issue_valid <= add_fire_s;
      add_res_valid_r <= add_issue_valid;
      if (add_fire_s) begin
        add_issue_idx  <= add_pick_idx_s;
        add_issue_func <= add_sel_func_s;
        add_issue_rob  <= add_sel_rob_s;
      end
      if (add_issue_valid) add_res_rob_r <= add_issue_rob;
    end
  end

  // Mul launch register; mul_issue_rob also tags the pending mul result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_issue_valid <= 1'b0;
      mul_issue_idx   <= {IDX_W{1'b0}};
      mul_issue_func  <= {FUNC_W{1'b0}};
      mul_issue_rob   <= {ROB_W{1'b0}};
    end else if (flush) begin
      mul_issue_valid <= 1'b0;
    end else begin
      mul_issue_valid <= mul_fire_s;
      if (mul_fire_s) begin
        mul_issue_idx  <= mul_pick_idx_s;
        mul_issue_func <= mul_sel_func_s;
        mul_issue_rob  <= mul_sel_rob_s;
      end
    end
  end

  // Mul FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Mul FSM next state; DONE is released only when it owns the CDB.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = MUL_IDLE;
    end else begin
      case (state_r)
        MUL_IDLE: state_nxt_s = mul_fire_s ? MUL_BUSY : MUL_IDLE;
        MUL_BUSY: state_nxt_s = (cnt_r == CNT_ZERO) ? MUL_DONE : MUL_BUSY;
        MUL_DONE: state_nxt_s = add_res_valid_r ? MUL_DONE : MUL_IDLE;
        default:  state_nxt_s = MUL_IDLE;
      endcase
    end
  end

  // Mul FSM decoded outputs.
  always_comb begin
    case (state_r)
      MUL_IDLE: begin mul_busy_s = 1'b0; mul_done_s = 1'b0; end
      MUL_BUSY: begin mul_busy_s = 1'b1; mul_done_s = 1'b0; end
      MUL_DONE: begin mul_busy_s = 1'b1; mul_done_s = 1'b1; end
      default:  begin mul_busy_s = 1'b0; mul_done_s = 1'b0; end
    endcase
  end

  // Execute-cycle counter; loaded with latency-1 so BUSY lasts exactly LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (flush) begin
      cnt_r <= CNT_ZERO;
    end else if (mul_fire_s) begin
      cnt_r <= (mul_sel_func_s == FUNC_DIV) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    end else if ((state_r == MUL_BUSY) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // CDB: add result wins; everything decodes directly from registers.
  always_comb begin
    mul_busy  = mul_busy_s;
    cdb_valid = add_res_valid_r | mul_done_s;
    cdb_src   = mul_done_s & ~add_res_valid_r;
    if (add_res_valid_r) begin
      cdb_rob = add_res_rob_r;
    end else if (mul_done_s) begin
      cdb_rob = mul_issue_rob;
    end else begin
      cdb_rob = {ROB_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Randomized bench for rs_issue_sched against a cycle-timestamp reference model.
module tb_rs_issue_sched;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [2:0]  add_req, mul_req;
  logic [11:0] add_func, mul_func;
  logic [8:0]  add_rob, mul_rob;
  logic [2:0]  add_grant, mul_grant;
  logic        add_issue_valid, mul_issue_valid, mul_busy, cdb_valid, cdb_src;
  logic [1:0]  add_issue_idx, mul_issue_idx;
  logic [3:0]  add_issue_func, mul_issue_func;
  logic [2:0]  add_issue_rob, mul_issue_rob, cdb_rob;

  rs_issue_sched dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .add_req(add_req), .add_func(add_func), .add_rob(add_rob),
    .mul_req(mul_req), .mul_func(mul_func), .mul_rob(mul_rob),
    .add_grant(add_grant), .mul_grant(mul_grant),
    .add_issue_valid(add_issue_valid), .add_issue_idx(add_issue_idx),
    .add_issue_func(add_issue_func), .add_issue_rob(add_issue_rob),
    .mul_issue_valid(mul_issue_valid), .mul_issue_idx(mul_issue_idx),
    .mul_issue_func(mul_issue_func), .mul_issue_rob(mul_issue_rob),
    .mul_busy(mul_busy), .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob(cdb_rob)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pointers, launches due next cycle, add result due on the
  // CDB, and the mul job expressed as the cycle its result becomes eligible.
  int         cyc;
  int         m_add_ptr, m_mul_ptr;
  bit         m_ai_v, m_mi_v, m_ares_v, m_mul_act;
  int         m_ai_idx, m_mi_idx, m_mul_done_at;
  logic [3:0] m_ai_func, m_mi_func;
  logic [2:0] m_ai_rob, m_mi_rob, m_ares_rob, m_mul_rob;
  logic [2:0] g;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr(input logic [2:0] req, input int ptr);
    for (int k = 0; k < 3; k++) begin
      if (req[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int i);
    return (i < 0) ? 32'd0 : (32'd1 << i);
  endfunction

  task automatic model_reset();
    m_add_ptr = 0; m_mul_ptr = 0;
    m_ai_v = 0; m_mi_v = 0; m_ares_v = 0; m_mul_act = 0;
    m_mul_done_at = 0;
  endtask

  task automatic step(input logic [2:0] areq, input logic [2:0] mreq, input logic fl,
                      input bit rnd, input logic [3:0] mf, input logic [2:0] mr,
                      output logic [2:0] ag_obs);
    int ag, mg, lat;
    bit done, ares_old, ev, es;
    logic [2:0] er;
    add_req = areq; mul_req = mreq; flush = fl;
    for (int e = 0; e < 3; e++) begin
      add_func[e*4 +: 4] = 4'($urandom_range(0, 7));
      add_rob[e*3 +: 3]  = 3'($urandom_range(0, 7));
      if (rnd) begin
        case ($urandom_range(0, 3))
          0, 1:    mul_func[e*4 +: 4] = 4'b0010;
          2:       mul_func[e*4 +: 4] = 4'b0011;
          default: mul_func[e*4 +: 4] = 4'($urandom_range(0, 15));
        endcase
        mul_rob[e*3 +: 3] = 3'($urandom_range(0, 7));
      end else begin
        mul_func[e*4 +: 4] = mf;
        mul_rob[e*3 +: 3]  = mr;
      end
    end
    #3;
    done = m_mul_act && (cyc >= m_mul_done_at);
    ag = (fl || done) ? -1 : rr(areq, m_add_ptr);
    mg = (fl || m_mul_act) ? -1 : rr(mreq, m_mul_ptr);
    ag_obs = add_grant;
    check_val("add_grant", add_grant, onehot(ag));
    check_val("mul_grant", mul_grant, onehot(mg));
    check_val("add_issue_valid", add_issue_valid, m_ai_v);
    if (m_ai_v) begin
      check_val("add_issue_idx", add_issue_idx, m_ai_idx);
      check_val("add_issue_func", add_issue_func, m_ai_func);
      check_val("add_issue_rob", add_issue_rob, m_ai_rob);
    end
    check_val("mul_issue_valid", mul_issue_valid, m_mi_v);
    if (m_mi_v) begin
      check_val("mul_issue_idx", mul_issue_idx, m_mi_idx);
      check_val("mul_issue_func", mul_issue_func, m_mi_func);
      check_val("mul_issue_rob", mul_issue_rob, m_mi_rob);
    end
    check_val("mul_busy", mul_busy, m_mul_act);
    if (m_ares_v) begin
      ev = 1; es = 0; er = m_ares_rob;
    end else if (done) begin
      ev = 1; es = 1; er = m_mul_rob;
    end else begin
      ev = 0; es = 0; er = 3'd0;
    end
    check_val("cdb_valid", cdb_valid, ev);
    check_val("cdb_src", cdb_src, es);
    check_val("cdb_rob", cdb_rob, er);
    @(posedge clk);
    #1;
    if (fl) begin
      model_reset();
    end else begin
      ares_old = m_ares_v;
      if (done && !ares_old) m_mul_act = 0;
      m_ares_v = m_ai_v;
      m_ares_rob = m_ai_rob;
      m_ai_v = (ag >= 0);
      if (ag >= 0) begin
        m_ai_idx = ag; m_ai_func = add_func[ag*4 +: 4]; m_ai_rob = add_rob[ag*3 +: 3];
        m_add_ptr = (ag + 1) % 3;
      end
      m_mi_v = (mg >= 0);
      if (mg >= 0) begin
        m_mi_idx = mg; m_mi_func = mul_func[mg*4 +: 4]; m_mi_rob = mul_rob[mg*3 +: 3];
        lat = (m_mi_func == 4'b0011) ? 6 : 3;
        m_mul_act = 1; m_mul_done_at = cyc + lat + 1; m_mul_rob = m_mi_rob;
        m_mul_ptr = (mg + 1) % 3;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(3'b000, 3'b000, 1'b0, 1'b1, 4'b0000, 3'd0, g);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_grants"}, {add_grant, mul_grant}, 32'd0);
    check_val({tag, "_issue"}, {add_issue_valid, add_issue_idx, add_issue_func, add_issue_rob}, 32'd0);
    check_val({tag, "_missue"}, {mul_issue_valid, mul_issue_idx, mul_issue_func, mul_issue_rob}, 32'd0);
    check_val({tag, "_cdb"}, {mul_busy, cdb_valid, cdb_src, cdb_rob}, 32'd0);
  endtask

  logic [2:0] rr_seq [4];

  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst_n = 1'b0; flush = 1'b0; add_req = 3'b000; mul_req = 3'b000;
    add_func = 12'd0; mul_func = 12'd0; add_rob = 9'd0; mul_rob = 9'd0;
    cyc = 0;
    model_reset();
    #2;
    check_all_zero("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin over a full add station.
    for (int k = 0; k < 4; k++) begin
      step(3'b111, 3'b000, 1'b0, 1'b1, 4'b0000, 3'd0, g);
      check_val("dir_add_rr", g, rr_seq[k]);
    end
    idle(3);

    // Single mul, then a div with a competing mul request held.
    step(3'b000, 3'b001, 1'b0, 1'b0, 4'b0010, 3'd5, g);
    idle(5);
    step(3'b000, 3'b001, 1'b0, 1'b0, 4'b0011, 3'd3, g);
    for (int k = 0; k < 9; k++) step(3'b000, 3'b010, 1'b0, 1'b0, 4'b0010, 3'd6, g);
    idle(5);

    // Mul reaching DONE with two adds in flight, adds requested throughout.
    step(3'b000, 3'b100, 1'b0, 1'b0, 4'b0010, 3'd7, g);
    idle(1);
    for (int k = 0; k < 6; k++) step(3'b111, 3'b000, 1'b0, 1'b1, 4'b0000, 3'd0, g);
    idle(4);

    // Flush with mul BUSY and an add in issue.
    step(3'b000, 3'b001, 1'b0, 1'b0, 4'b0011, 3'd2, g);
    step(3'b001, 3'b000, 1'b0, 1'b1, 4'b0000, 3'd0, g);
    step(3'b111, 3'b111, 1'b1, 1'b1, 4'b0000, 3'd0, g);
    check_val("flush_no_grant", g, 32'd0);
    idle(1);
    step(3'b111, 3'b000, 1'b0, 1'b1, 4'b0000, 3'd0, g);
    check_val("flush_ptr0", g, 32'd1);
    idle(3);

    // Asynchronous reset while the mul result is waiting in DONE.
    step(3'b010, 3'b000, 1'b0, 1'b1, 4'b0000, 3'd0, g);
    step(3'b000, 3'b010, 1'b0, 1'b0, 4'b0010, 3'd4, g);
    for (int k = 0; k < 20 && !(m_mul_act && cyc >= m_mul_done_at); k++) idle(1);
    add_req = 3'b000; mul_req = 3'b000; flush = 1'b0;
    #1;
    check_val("pre_rst_cdb_valid", cdb_valid, 32'd1);
    check_val("pre_rst_cdb_src", cdb_src, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    idle(2);
    step(3'b111, 3'b111, 1'b0, 1'b1, 4'b0000, 3'd0, g);
    check_val("rst_ptr0", g, 32'd1);
    idle(4);

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 800; k++) begin
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 39) == 0), 1'b1, 4'b0000, 3'd0, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
